// File: rtl/dfi_chan_mux.sv
// DFI channel multiplexer: per-channel one-entry command buffers, TDM or
// round-robin issue to a single PHY port, and tagged read-return fan-out.
module dfi_chan_mux #(
  parameter  int NUM_CHAN    = 2,
  parameter  int WORD_W      = 32,
  parameter  int NUM_WORDS   = 4,
  parameter  int BANK_W      = 2,
  parameter  int ADDR_W      = 14,
  parameter  int INIT_CYCLES = 16,
  localparam int CW          = $clog2(NUM_CHAN),
  localparam int DW          = NUM_WORDS * WORD_W
) (
  input  logic                       clk,
  input  logic                       reset_poweron_n,
  input  logic                       cfg__dfi__arb_mode,
  input  logic [NUM_CHAN-1:0]        mmc__dfi__cmd_valid,
  output logic [NUM_CHAN-1:0]        dfi__mmc__cmd_ready,
  input  logic [2*NUM_CHAN-1:0]      mmc__dfi__cmd,
  input  logic [BANK_W*NUM_CHAN-1:0] mmc__dfi__bank,
  input  logic [ADDR_W*NUM_CHAN-1:0] mmc__dfi__addr,
  input  logic [DW*NUM_CHAN-1:0]     mmc__dfi__data,
  output logic                       dfi__mmc__init_done,
  output logic                       dfi__phy__cs,
  output logic [1:0]                 dfi__phy__cmd,
  output logic [BANK_W-1:0]          dfi__phy__bank,
  output logic [ADDR_W-1:0]          dfi__phy__addr,
  output logic [DW-1:0]              dfi__phy__data,
  output logic [CW-1:0]              dfi__phy__chan,
  input  logic                       phy__dfi__valid,
  input  logic [CW-1:0]              phy__dfi__chan,
  input  logic [DW-1:0]              phy__dfi__data,
  output logic [NUM_CHAN-1:0]        dfi__mmc__valid,
  output logic [DW*NUM_CHAN-1:0]     dfi__mmc__data,
  output logic                       dfi__mmc__err
);

  localparam int CNT_W = $clog2(INIT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_WAIT,
    S_RUN
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               run;

  logic [NUM_CHAN-1:0] full;
  logic [NUM_CHAN-1:0] accept;
  logic [1:0]          b_cmd  [NUM_CHAN];
  logic [BANK_W-1:0]   b_bank [NUM_CHAN];
  logic [ADDR_W-1:0]   b_addr [NUM_CHAN];
  logic [DW-1:0]       b_data [NUM_CHAN];

  logic [CW-1:0] slot;
  logic [CW-1:0] rr;
  logic [CW-1:0] cand;
  logic [CW-1:0] gidx;
  logic          gnt;
  logic          ret_ok;

  always_ff @(posedge clk) begin
    if (!reset_poweron_n) begin
      state <= S_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_WAIT) cnt <= cnt + CNT_W'(1);
    end
  end

  // WAIT spends INIT_CYCLES+1 edges so RUN lands 17 edges after release
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_INIT: state_nxt = S_WAIT;
      S_WAIT: if (cnt == CNT_W'(INIT_CYCLES)) state_nxt = S_RUN;
      S_RUN:  state_nxt = S_RUN;
      default: state_nxt = S_INIT;
    endcase
  end

  assign run                 = (state == S_RUN);
  assign dfi__mmc__init_done = run;
  assign dfi__mmc__cmd_ready = {NUM_CHAN{run}} & ~full;
  assign accept              = mmc__dfi__cmd_valid & dfi__mmc__cmd_ready;

  always_comb begin
    gnt  = 1'b0;
    gidx = '0;
    cand = '0;
    if (run) begin
      if (!cfg__dfi__arb_mode) begin
        if (full[slot]) begin
          gnt  = 1'b1;
          gidx = slot;
        end
      end else begin
        for (int i = 0; i < NUM_CHAN; i++) begin
          cand = rr + CW'(i);
          if (!gnt && full[cand]) begin
            gnt  = 1'b1;
            gidx = cand;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_poweron_n) begin
      full <= '0;
      for (int c = 0; c < NUM_CHAN; c++) begin
        b_cmd[c]  <= '0;
        b_bank[c] <= '0;
        b_addr[c] <= '0;
        b_data[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CHAN; c++) begin
        if (accept[c]) begin
          full[c]   <= 1'b1;
          b_cmd[c]  <= mmc__dfi__cmd[c*2 +: 2];
          b_bank[c] <= mmc__dfi__bank[c*BANK_W +: BANK_W];
          b_addr[c] <= mmc__dfi__addr[c*ADDR_W +: ADDR_W];
          b_data[c] <= mmc__dfi__data[c*DW +: DW];
        end else if (gnt && gidx == CW'(c)) begin
          full[c] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_poweron_n) begin
      slot           <= '0;
      rr             <= '0;
      dfi__phy__cs   <= 1'b0;
      dfi__phy__cmd  <= '0;
      dfi__phy__bank <= '0;
      dfi__phy__addr <= '0;
      dfi__phy__data <= '0;
      dfi__phy__chan <= '0;
    end else begin
      if (run) slot <= slot + CW'(1);
      if (gnt && cfg__dfi__arb_mode) rr <= gidx + CW'(1);
      dfi__phy__cs   <= gnt;
      dfi__phy__cmd  <= gnt ? b_cmd[gidx]  : '0;
      dfi__phy__bank <= gnt ? b_bank[gidx] : '0;
      dfi__phy__addr <= gnt ? b_addr[gidx] : '0;
      dfi__phy__data <= gnt ? b_data[gidx] : '0;
      dfi__phy__chan <= gnt ? gidx : '0;
    end
  end

  assign ret_ok = phy__dfi__valid && run &&
                  (int'(phy__dfi__chan) < NUM_CHAN);

  always_ff @(posedge clk) begin
    if (!reset_poweron_n) begin
      dfi__mmc__valid <= '0;
      dfi__mmc__data  <= '0;
      dfi__mmc__err   <= 1'b0;
    end else begin
      dfi__mmc__valid <= '0;
      if (ret_ok) begin
        dfi__mmc__valid[phy__dfi__chan]         <= 1'b1;
        dfi__mmc__data[phy__dfi__chan*DW +: DW] <= phy__dfi__data;
      end else if (phy__dfi__valid) begin
        dfi__mmc__err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dfi_chan_mux.sv
// Directed bench for dfi_chan_mux: init timing, TDM and round-robin
// issue order, read-return fan-out, error flag and mid-run reset.
module tb_dfi_chan_mux;

  localparam int NC = 4;
  localparam int CW = 2;
  localparam int DW = 128;
  localparam int BW = 2;
  localparam int AW = 14;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mode;
  logic [NC-1:0]     cvalid;
  logic [NC-1:0]     cready;
  logic [2*NC-1:0]   ccmd;
  logic [BW*NC-1:0]  cbank;
  logic [AW*NC-1:0]  caddr;
  logic [DW*NC-1:0]  cdata;
  logic              init_done;
  logic              cs;
  logic [1:0]        pcmd;
  logic [BW-1:0]     pbank;
  logic [AW-1:0]     paddr;
  logic [DW-1:0]     pdata;
  logic [CW-1:0]     pchan;
  logic              rvalid;
  logic [CW-1:0]     rchan;
  logic [DW-1:0]     rdata;
  logic [NC-1:0]     mvalid;
  logic [DW*NC-1:0]  mdata;
  logic              err;

  int checks = 0;
  int errors = 0;

  dfi_chan_mux #(
    .NUM_CHAN(NC), .WORD_W(32), .NUM_WORDS(4),
    .BANK_W(BW), .ADDR_W(AW), .INIT_CYCLES(16)
  ) dut (
    .clk                 (clk),
    .reset_poweron_n     (rst_n),
    .cfg__dfi__arb_mode  (mode),
    .mmc__dfi__cmd_valid (cvalid),
    .dfi__mmc__cmd_ready (cready),
    .mmc__dfi__cmd       (ccmd),
    .mmc__dfi__bank      (cbank),
    .mmc__dfi__addr      (caddr),
    .mmc__dfi__data      (cdata),
    .dfi__mmc__init_done (init_done),
    .dfi__phy__cs        (cs),
    .dfi__phy__cmd       (pcmd),
    .dfi__phy__bank      (pbank),
    .dfi__phy__addr      (paddr),
    .dfi__phy__data      (pdata),
    .dfi__phy__chan      (pchan),
    .phy__dfi__valid     (rvalid),
    .phy__dfi__chan      (rchan),
    .phy__dfi__data      (rdata),
    .dfi__mmc__valid     (mvalid),
    .dfi__mmc__data      (mdata),
    .dfi__mmc__err       (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_ch(input int c, input logic [1:0] cm,
                        input logic [BW-1:0] bk, input logic [AW-1:0] ad,
                        input logic [DW-1:0] dt);
    ccmd[c*2 +: 2]   = cm;
    cbank[c*BW +: BW] = bk;
    caddr[c*AW +: AW] = ad;
    cdata[c*DW +: DW] = dt;
  endtask

  initial begin
    logic [DW-1:0] pat_a5;
    logic [DW-1:0] pat_12;
    logic [DW-1:0] d2;
    int            ch;
    pat_a5 = {4{32'hA5A5_A5A5}};
    pat_12 = {4{32'h1234_5678}};
    d2     = {4{32'hC0DE_0002}};
    rst_n = 1'b0;
    mode = 1'b0;
    cvalid = '0;
    ccmd = '0;
    cbank = '0;
    caddr = '0;
    cdata = '0;
    rvalid = 1'b0;
    rchan = '0;
    rdata = '0;

    repeat (3) step();
    chk("rst_init_done", 128'(init_done), 128'(0));
    chk("rst_ready", 128'(cready), 128'(0));
    chk("rst_cs", 128'(cs), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_mvalid", 128'(mvalid), 128'(0));

    // Release: E0 moves INIT->WAIT, RUN is reached at E17
    rst_n = 1'b1;
    step();
    for (int n = 1; n <= 17; n++) begin
      step();
      if (n == 6) begin
        chk("wait_ret_err", 128'(err), 128'(1));
        chk("wait_ret_mvalid", 128'(mvalid), 128'(0));
        rvalid = 1'b0;
      end
      if (n < 17) begin
        chk($sformatf("wait_ready_%0d", n), 128'(cready), 128'(0));
        if (n == 16) chk("init_done_16", 128'(init_done), 128'(0));
      end else begin
        chk("init_done_17", 128'(init_done), 128'(1));
        chk("run_ready", 128'(cready), 128'hF);
      end
      if (n == 5) begin
        rvalid = 1'b1;
        rchan  = 2'd0;
        rdata  = pat_12;
      end
    end

    // Fixed TDM, channel 2 only: slot 2 issues at E20, E24, E28
    mode = 1'b0;
    set_ch(2, 2'b10, 2'd1, 14'h123, d2);
    cvalid = 4'b0100;
    for (int n = 18; n <= 28; n++) begin
      step();
      if (n == 20 || n == 24 || n == 28) begin
        chk($sformatf("tdm_cs_%0d", n), 128'(cs), 128'(1));
        chk($sformatf("tdm_chan_%0d", n), 128'(pchan), 128'(2));
        chk($sformatf("tdm_addr_%0d", n), 128'(paddr), 128'h123);
        if (n == 20) begin
          chk("tdm_cmd", 128'(pcmd), 128'(2));
          chk("tdm_bank", 128'(pbank), 128'(1));
          chk("tdm_data", pdata, d2);
        end
      end else begin
        chk($sformatf("tdm_idle_cs_%0d", n), 128'(cs), 128'(0));
        chk($sformatf("tdm_idle_addr_%0d", n), 128'(paddr), 128'(0));
        chk($sformatf("tdm_idle_data_%0d", n), pdata, 128'(0));
      end
      if (n == 21) chk("tdm_full_ready", 128'(cready), 128'hB);
      if (n == 24) chk("tdm_freed_ready", 128'(cready), 128'hF);
      if (n == 25) cvalid = '0;
    end

    // Round-robin, all channels streaming: 0,1,2,3,0 then drain 1,2,3
    mode = 1'b1;
    for (int c = 0; c < NC; c++)
      set_ch(c, 2'(c), 2'(c), 14'(14'h100 + c), {4{32'hD000_0000 + 32'(c)}});
    cvalid = 4'hF;
    for (int n = 29; n <= 38; n++) begin
      step();
      if (n == 29 || n == 38) begin
        chk($sformatf("rr_idle_cs_%0d", n), 128'(cs), 128'(0));
        chk($sformatf("rr_idle_chan_%0d", n), 128'(pchan), 128'(0));
      end else begin
        ch = (n - 30) % 4;
        chk($sformatf("rr_cs_%0d", n), 128'(cs), 128'(1));
        chk($sformatf("rr_chan_%0d", n), 128'(pchan), 128'(ch));
        chk($sformatf("rr_addr_%0d", n), 128'(paddr), 128'(32'h100 + ch));
        chk($sformatf("rr_cmd_%0d", n), 128'(pcmd), 128'(ch));
        chk($sformatf("rr_data_%0d", n), pdata,
            {4{32'hD000_0000 + 32'(ch)}});
      end
      if (n == 34) cvalid = '0;
    end

    // Read return fan-out
    mode = 1'b0;
    rvalid = 1'b1;
    rchan  = 2'd1;
    rdata  = pat_a5;
    step();
    chk("ret1_valid", 128'(mvalid), 128'h2);
    chk("ret1_data1", mdata[DW*1 +: DW], pat_a5);
    chk("ret1_data0", mdata[DW*0 +: DW], 128'(0));
    chk("ret1_err_sticky", 128'(err), 128'(1));
    rvalid = 1'b0;
    step();
    chk("ret1_pulse_end", 128'(mvalid), 128'(0));
    chk("ret1_hold", mdata[DW*1 +: DW], pat_a5);
    rvalid = 1'b1;
    rchan  = 2'd0;
    rdata  = pat_12;
    step();
    rvalid = 1'b0;
    chk("ret0_valid", 128'(mvalid), 128'h1);
    chk("ret0_data0", mdata[DW*0 +: DW], pat_12);
    chk("ret0_data1_hold", mdata[DW*1 +: DW], pat_a5);

    // Reset with channel 3 buffered
    set_ch(3, 2'b01, 2'd3, 14'h3AA, {4{32'h3333_3333}});
    cvalid = 4'b1000;
    step();
    cvalid = '0;
    chk("ch3_full_ready", 128'(cready), 128'h7);
    rst_n = 1'b0;
    step();
    chk("midrst_cs", 128'(cs), 128'(0));
    chk("midrst_ready", 128'(cready), 128'(0));
    chk("midrst_init_done", 128'(init_done), 128'(0));
    chk("midrst_err", 128'(err), 128'(0));
    chk("midrst_mdata", mdata[DW*0 +: DW], 128'(0));
    step();
    rst_n = 1'b1;
    step();
    repeat (17) step();
    chk("reinit_done", 128'(init_done), 128'(1));
    chk("reinit_ready", 128'(cready), 128'hF);
    mode = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      chk($sformatf("reinit_no_stale_%0d", n), 128'(cs), 128'(0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
